// File: rtl/alu_pkg.sv
// Shared types and helpers for the multi-cycle ALU.
// Optional divider is controlled by the ALU_MC_DIV_EN macro.
package alu_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned SHAMT_W   = $clog2(WIDTH_DEF);

    typedef enum logic [3:0] {
        OpAdd   = 4'b0000,
        OpSub   = 4'b0001,
        OpAnd   = 4'b0010,
        OpOr    = 4'b0011,
        OpXor   = 4'b0100,
        OpSll   = 4'b0101,
        OpSrl   = 4'b0110,
        OpSra   = 4'b0111,
        OpSlt   = 4'b1000,
        OpSltu  = 4'b1001,
        OpEq    = 4'b1010,
        OpNe    = 4'b1011,
        OpMul   = 4'b1100,
        OpMulhu = 4'b1101,
        OpDivu  = 4'b1110,
        OpRemu  = 4'b1111
    } op_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_t;

    function automatic logic is_iterative(input op_t op);
`ifdef ALU_MC_DIV_EN
        return (op == OpMul) || (op == OpMulhu) || (op == OpDivu) || (op == OpRemu);
`else
        return (op == OpMul) || (op == OpMulhu);
`endif
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative engine: shift-add multiplier and, with ALU_MC_DIV_EN, a restoring divider.
// hi/lo present the register values after the current step, so they are final when done=1.
module alu_mc_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic             busy_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    // hi_q accumulates the partial product; lo_q shifts the multiplier out as product bits enter
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

`ifdef ALU_MC_DIV_EN
    logic             div_q;
    logic             is_div;
    logic [WIDTH:0]   div_part;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    assign is_div = (op == OpDivu) || (op == OpRemu);

    // hi_q is the partial remainder, lo_q shifts the dividend out and the quotient in
    always_comb begin
        div_part = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_part - {1'b0, opnd_q};
        div_hi   = div_diff[WIDTH] ? div_part[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_lo   = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end

    assign hi = div_q ? div_hi : mul_hi;
    assign lo = div_q ? div_lo : mul_lo;
`else
    logic unused_op;
    assign unused_op = ^op;
    assign hi        = mul_hi;
    assign lo        = mul_lo;
`endif

    assign done = busy_q && (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
`ifdef ALU_MC_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            hi_q   <= '0;
`ifdef ALU_MC_DIV_EN
            div_q  <= is_div;
            lo_q   <= is_div ? a : b;
            opnd_q <= is_div ? b : a;
`else
            lo_q   <= b;
            opnd_q <= a;
`endif
        end else if (busy_q) begin
            hi_q  <= hi;
            lo_q  <= lo;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides; single-cycle ops finish in one cycle.
// Define ALU_MC_DIV_EN to build the iterative DIVU/REMU path, otherwise they flag illegal_op.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal_op
);

    localparam int unsigned ShW = $clog2(WIDTH);

    state_t           state_q;
    op_t              op_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;

    op_t              op_in;
    logic [ShW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             xfer;
    logic             iter_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_res;

    assign op_in      = op_t'(op);
    assign shamt      = b[ShW-1:0];
    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign xfer       = in_valid && in_ready;
    assign iter_start = xfer && is_iterative(op_in);

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op_in)
            OpAdd:   alu_res = a + b;
            OpSub:   alu_res = a - b;
            OpAnd:   alu_res = a & b;
            OpOr:    alu_res = a | b;
            OpXor:   alu_res = a ^ b;
            OpSll:   alu_res = a << shamt;
            OpSrl:   alu_res = a >> shamt;
            OpSra:   alu_res = $unsigned($signed(a) >>> shamt);
            OpSlt:   alu_res[0] = $signed(a) < $signed(b);
            OpSltu:  alu_res[0] = a < b;
            OpEq:    alu_res[0] = (a == b);
            OpNe:    alu_res[0] = (a != b);
            OpMul, OpMulhu: alu_res = '0;
`ifdef ALU_MC_DIV_EN
            OpDivu, OpRemu: alu_res = '0;
`else
            OpDivu, OpRemu: alu_ill = 1'b1;
`endif
            default: alu_res = '0;
        endcase
    end

    alu_mc_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (iter_start),
        .op    (op_in),
        .a     (a),
        .b     (b),
        .done  (iter_done),
        .hi    (iter_hi),
        .lo    (iter_lo)
    );

    // MULHU and REMU take the upper register, MUL and DIVU the lower one
    assign iter_res = ((op_q == OpMulhu) || (op_q == OpRemu)) ? iter_hi : iter_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= OpAdd;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (xfer) begin
                        op_q <= op_in;
                        if (is_iterative(op_in)) begin
                            state_q <= StBusy;
                        end else begin
                            state_q   <= StDone;
                            result_q  <= alu_res;
                            zero_q    <= (alu_res == '0);
                            illegal_q <= alu_ill;
                        end
                    end
                end
                StBusy: begin
                    if (iter_done) begin
                        state_q   <= StDone;
                        result_q  <= iter_res;
                        zero_q    <= (iter_res == '0);
                        illegal_q <= 1'b0;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign result     = result_q;
    assign zero       = zero_q;
    assign illegal_op = illegal_q;

endmodule
